// File: rtl/la_cmd_sequencer_pkg.sv
// Shared definitions for the LA command sequencer: command and status codes,
// FSM state encoding and the default datapath width.
package la_seq_pkg;

  localparam int unsigned DEFAULT_DATA_W = 16;

  // Command codes carried on la_cmd.
  localparam logic [2:0] CMD_NOP     = 3'd0;
  localparam logic [2:0] CMD_SET_OEB = 3'd1;
  localparam logic [2:0] CMD_WRITE   = 3'd2;
  localparam logic [2:0] CMD_LOAD    = 3'd3;
  localparam logic [2:0] CMD_RUN     = 3'd4;
  localparam logic [2:0] CMD_CLEAR   = 3'd5;

  // Status codes returned on la_status.
  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_BAD   = 2'b01;
  localparam logic [1:0] ST_ABORT = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StDecode,
    StRun,
    StDone
  } seq_state_e;

endpackage

// File: rtl/la_cmd_sequencer_if.sv
// Logic-analyzer command bus plus the user IO pad bundle.
//   master : firmware side (drives request, command, argument, abort)
//   slave  : sequencer side (drives ack, busy, status, count, pads, irq)
interface la_cmd_sequencer_if #(
  parameter int unsigned DATA_W = 16
);
  logic              la_req_tgl;
  logic [2:0]        la_cmd;
  logic [DATA_W-1:0] la_arg;
  logic              la_abort;
  logic              la_ack_tgl;
  logic              la_busy;
  logic [1:0]        la_status;
  logic [DATA_W-1:0] la_count;
  logic [DATA_W-1:0] io_out;
  logic [DATA_W-1:0] io_oeb;
  logic              irq;

  modport master (
    output la_req_tgl, la_cmd, la_arg, la_abort,
    input  la_ack_tgl, la_busy, la_status, la_count, io_out, io_oeb, irq
  );

  modport slave (
    input  la_req_tgl, la_cmd, la_arg, la_abort,
    output la_ack_tgl, la_busy, la_status, la_count, io_out, io_oeb, irq
  );
endinterface

// File: rtl/la_sync2.sv
// Two-flop synchroniser, parameterised width, asynchronous active-low reset.
//   clk_i  : destination clock
//   rst_ni : async reset, active low, clears both stages
//   d_i    : asynchronous input
//   q_o    : synchronised output (two cycles of latency)
module la_sync2 #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);
  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/la_cmd_sequencer.sv
// Sequences a counter/IO datapath from toggle-handshaked LA commands.
//   clock  : system clock
//   resetb : async reset, active low
//   bus    : slave side of the LA command bus and IO pad bundle
// A command is issued when the synchronised request toggle differs from the
// last accepted parity; completion is signalled by copying that parity back
// to la_ack_tgl. RUN commands also pulse irq on completion or abort.
import la_seq_pkg::*;

module la_cmd_sequencer #(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input logic               clock,
  input logic               resetb,
  la_cmd_sequencer_if.slave bus
);
  logic              req_sync;
  logic              abort_sync;

  seq_state_e        state_q;
  logic              req_seen_q;
  logic [2:0]        cmd_q;
  logic [DATA_W-1:0] arg_q;
  logic [DATA_W-1:0] remaining_q;
  logic [DATA_W-1:0] count_q;
  logic [DATA_W-1:0] io_out_q;
  logic [DATA_W-1:0] io_oeb_q;
  logic              ack_q;
  logic [1:0]        status_q;
  logic              irq_q;

  logic [DATA_W-1:0] count_inc;

  la_sync2 #(
    .Width (1)
  ) u_sync_req (
    .clk_i  (clock),
    .rst_ni (resetb),
    .d_i    (bus.la_req_tgl),
    .q_o    (req_sync)
  );

  la_sync2 #(
    .Width (1)
  ) u_sync_abort (
    .clk_i  (clock),
    .rst_ni (resetb),
    .d_i    (bus.la_abort),
    .q_o    (abort_sync)
  );

  // Wraps silently at 2^DATA_W.
  assign count_inc = count_q + DATA_W'(1);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q     <= StIdle;
      req_seen_q  <= 1'b0;
      cmd_q       <= CMD_NOP;
      arg_q       <= '0;
      remaining_q <= '0;
      count_q     <= '0;
      io_out_q    <= '0;
      io_oeb_q    <= '1;
      ack_q       <= 1'b0;
      status_q    <= ST_OK;
      irq_q       <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_sync != req_seen_q) begin
            cmd_q      <= bus.la_cmd;
            arg_q      <= bus.la_arg;
            req_seen_q <= req_sync;
            state_q    <= StDecode;
          end
        end

        StDecode: begin
          status_q <= ST_OK;
          state_q  <= StDone;
          case (cmd_q)
            CMD_NOP: ;
            CMD_SET_OEB: io_oeb_q <= arg_q;
            CMD_WRITE:   io_out_q <= arg_q;
            CMD_LOAD:    count_q  <= arg_q;
            CMD_RUN: begin
              // A zero-length run completes straight away but still pulses irq.
              if (arg_q != '0) begin
                remaining_q <= arg_q;
                state_q     <= StRun;
              end
            end
            CMD_CLEAR: begin
              count_q  <= '0;
              io_out_q <= '0;
            end
            default: status_q <= ST_BAD;
          endcase
        end

        StRun: begin
          // Abort wins over the final increment.
          if (abort_sync) begin
            status_q <= ST_ABORT;
            state_q  <= StDone;
          end else begin
            count_q     <= count_inc;
            io_out_q    <= count_inc;
            remaining_q <= remaining_q - DATA_W'(1);
            if (remaining_q == DATA_W'(1)) begin
              state_q <= StDone;
            end
          end
        end

        StDone: begin
          ack_q   <= req_seen_q;
          irq_q   <= (cmd_q == CMD_RUN);
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.la_ack_tgl = ack_q;
  assign bus.la_busy    = (state_q != StIdle);
  assign bus.la_status  = status_q;
  assign bus.la_count   = count_q;
  assign bus.io_out     = io_out_q;
  assign bus.io_oeb     = io_oeb_q;
  assign bus.irq        = irq_q;
endmodule

// File: tb/tb_la_cmd_sequencer.sv
// Scoreboard bench: the driver pushes the expected completion for each
// command; a monitor pops and compares whenever la_ack_tgl changes.
module tb_la_cmd_sequencer;
  localparam int unsigned W = 16;

  logic clock = 1'b0;
  logic resetb = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic req = 1'b0;
  logic last_ack = 1'b0;

  typedef struct {
    logic         ack;
    logic [1:0]   status;
    logic [W-1:0] count;
    logic [W-1:0] out;
    logic [W-1:0] oeb;
    logic         irq;
    int           at_edge;
  } exp_t;

  exp_t exp_q[$];

  la_cmd_sequencer_if #(.DATA_W(W)) bus ();

  la_cmd_sequencer #(
    .DATA_W (W)
  ) dut (
    .clock  (clock),
    .resetb (resetb),
    .bus    (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one completion per ack toggle; irq is only legal alongside one.
  always @(negedge clock) begin
    exp_t e;
    if (!resetb) begin
      last_ack = 1'b0;
    end else if (bus.la_ack_tgl !== last_ack) begin
      last_ack = bus.la_ack_tgl;
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'(bus.la_ack_tgl), 32'(~bus.la_ack_tgl));
      end else begin
        e = exp_q.pop_front();
        chk("ack_val", 32'(bus.la_ack_tgl), 32'(e.ack));
        chk("ack_edge", 32'(cyc), 32'(e.at_edge));
        chk("status", 32'(bus.la_status), 32'(e.status));
        chk("count", 32'(bus.la_count), 32'(e.count));
        chk("io_out", 32'(bus.io_out), 32'(e.out));
        chk("io_oeb", 32'(bus.io_oeb), 32'(e.oeb));
        chk("irq", 32'(bus.irq), 32'(e.irq));
        chk("busy_after_ack", 32'(bus.la_busy), 32'd0);
      end
    end else if (bus.irq !== 1'b0) begin
      chk("stray_irq", 32'(bus.irq), 32'd0);
    end
  end

  // Toggle a request at a negedge; n is the first edge that samples it.
  task automatic send(input logic [2:0] cmd, input logic [W-1:0] arg, output int n);
    @(negedge clock);
    bus.la_cmd = cmd;
    bus.la_arg = arg;
    req = ~req;
    bus.la_req_tgl = req;
    n = cyc + 1;
  endtask

  task automatic expect_done(input logic [1:0] st, input logic [W-1:0] cnt,
                             input logic [W-1:0] out, input logic [W-1:0] oeb,
                             input logic irq, input int at_edge);
    exp_t e;
    e.ack = req;
    e.status = st;
    e.count = cnt;
    e.out = out;
    e.oeb = oeb;
    e.irq = irq;
    e.at_edge = at_edge;
    exp_q.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clock);
    if (exp_q.size() != 0) begin
      chk("timeout_pending", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(negedge clock);
  endtask

  task automatic cmd_simple(input logic [2:0] cmd, input logic [W-1:0] arg,
                            input logic [1:0] st, input logic [W-1:0] cnt,
                            input logic [W-1:0] out, input logic [W-1:0] oeb,
                            input logic irq, input int lat);
    int n;
    send(cmd, arg, n);
    expect_done(st, cnt, out, oeb, irq, n + lat);
    wait_done();
  endtask

  task automatic chk_reset_vals();
    chk("rst_oeb", 32'(bus.io_oeb), 32'h0000_FFFF);
    chk("rst_out", 32'(bus.io_out), 32'd0);
    chk("rst_count", 32'(bus.la_count), 32'd0);
    chk("rst_ack", 32'(bus.la_ack_tgl), 32'd0);
    chk("rst_busy", 32'(bus.la_busy), 32'd0);
    chk("rst_status", 32'(bus.la_status), 32'd0);
    chk("rst_irq", 32'(bus.irq), 32'd0);
  endtask

  initial begin
    int n;
    int m;
    logic [W-1:0] seq [4];
    seq[0] = 16'hFFFF;
    seq[1] = 16'h0000;
    seq[2] = 16'h0001;
    seq[3] = 16'h0002;

    bus.la_req_tgl = 1'b0;
    bus.la_cmd = 3'd0;
    bus.la_arg = '0;
    bus.la_abort = 1'b0;
    repeat (3) @(negedge clock);
    chk_reset_vals();
    resetb = 1'b1;
    repeat (2) @(negedge clock);

    // Basic writes: 4-edge ack latency.
    send(3'd1, 16'h0000, n);
    expect_done(2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0, n + 4);
    repeat (4) @(negedge clock); // cyc == n+3: DECODE done, DONE state
    chk("busy_mid_cmd", 32'(bus.la_busy), 32'd1);
    wait_done();
    cmd_simple(3'd2, 16'hAB60, 2'b00, 16'h0000, 16'hAB60, 16'h0000, 1'b0, 4);

    // LOAD then RUN 1.
    cmd_simple(3'd3, 16'hAB60, 2'b00, 16'hAB60, 16'hAB60, 16'h0000, 1'b0, 4);
    cmd_simple(3'd4, 16'h0001, 2'b00, 16'hAB61, 16'hAB61, 16'h0000, 1'b1, 5);

    // Wrap-around run: increments land on edges n+4..n+7.
    cmd_simple(3'd3, 16'hFFFE, 2'b00, 16'hFFFE, 16'hAB61, 16'h0000, 1'b0, 4);
    send(3'd4, 16'h0004, n);
    expect_done(2'b00, 16'h0002, 16'h0002, 16'h0000, 1'b1, n + 8);
    repeat (5) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      chk("run_seq", 32'(bus.la_count), 32'(seq[i]));
      @(negedge clock);
    end
    wait_done();

    // Bad command, RUN 0, NOP, SET_OEB, CLEAR.
    cmd_simple(3'd6, 16'h1234, 2'b01, 16'h0002, 16'h0002, 16'h0000, 1'b0, 4);
    cmd_simple(3'd4, 16'h0000, 2'b00, 16'h0002, 16'h0002, 16'h0000, 1'b1, 4);
    cmd_simple(3'd7, 16'h0000, 2'b01, 16'h0002, 16'h0002, 16'h0000, 1'b0, 4);
    cmd_simple(3'd0, 16'hFFFF, 2'b00, 16'h0002, 16'h0002, 16'h0000, 1'b0, 4);
    cmd_simple(3'd1, 16'h00FF, 2'b00, 16'h0002, 16'h0002, 16'h00FF, 1'b0, 4);
    cmd_simple(3'd5, 16'hFFFF, 2'b00, 16'h0000, 16'h0000, 16'h00FF, 1'b0, 4);

    // Second toggle during RUN stays pending until the first completes.
    send(3'd4, 16'd10, n);
    expect_done(2'b00, 16'h000A, 16'h000A, 16'h00FF, 1'b1, n + 14);
    repeat (6) @(negedge clock);
    send(3'd2, 16'h5A5A, m);
    expect_done(2'b00, 16'h000A, 16'h5A5A, 16'h00FF, 1'b0, n + 17);
    wait_done();

    // Abort: raise la_abort once count reaches 100; two more increments
    // slip through the synchroniser before the RUN sees it.
    cmd_simple(3'd3, 16'h0000, 2'b00, 16'h0000, 16'h5A5A, 16'h00FF, 1'b0, 4);
    send(3'd4, 16'd1000, n);
    for (int i = 0; i < 2000 && bus.la_count != 16'd100; i++) @(negedge clock);
    chk("abort_reach100", 32'(bus.la_count), 32'd100);
    bus.la_abort = 1'b1;
    m = cyc;
    expect_done(2'b10, 16'd102, 16'd102, 16'h00FF, 1'b1, m + 4);
    wait_done();
    bus.la_abort = 1'b0;

    // Reset mid-run clears everything immediately.
    send(3'd4, 16'd1000, n);
    repeat (20) @(negedge clock);
    chk("busy_before_rst", 32'(bus.la_busy), 32'd1);
    resetb = 1'b0;
    req = 1'b0;
    bus.la_req_tgl = 1'b0;
    #1;
    exp_q.delete();
    chk_reset_vals();
    repeat (2) @(negedge clock);
    resetb = 1'b1;
    repeat (2) @(negedge clock);
    cmd_simple(3'd2, 16'h0001, 2'b00, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
